// File: rtl/ysyx_arb_pkg.sv
// Shared types and defaults for the IFU/LSU memory arbiter.
package ysyx_arb_pkg;

  localparam int ARB_AW_DEF = 32;
  localparam int ARB_DW_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IFU = 1'b0,
    GNT_LSU = 1'b1
  } arb_grant_e;

endpackage

// File: rtl/ysyx_arb_pick.sv
// Combinational winner selection between the IFU and LSU requesters.
// Build option YSYX_ARB_RR_EN: ties alternate against last_grant;
// otherwise the LSU always wins a tie and last_grant does not exist.
module ysyx_arb_pick
  import ysyx_arb_pkg::*;
(
  input  logic       ifu_valid,
  input  logic       lsu_valid,
`ifdef YSYX_ARB_RR_EN
  input  arb_grant_e last_grant,
`endif
  output arb_grant_e grant
);

  // Pick the single winner; a lone requester always wins.
  always_comb begin
    grant = GNT_IFU;
    if (ifu_valid && lsu_valid) begin
`ifdef YSYX_ARB_RR_EN
      grant = (last_grant == GNT_IFU) ? GNT_LSU : GNT_IFU;
`else
      grant = GNT_LSU;
`endif
    end else if (lsu_valid) begin
      grant = GNT_LSU;
    end
  end

endmodule

// File: rtl/ysyx_mem_arbiter.sv
// Two-requester (IFU, LSU) arbiter onto a single memory port, one
// transaction outstanding at a time.
// Build option YSYX_ARB_RR_EN: round-robin tie breaking (default: LSU priority).
//
// state    | meaning
// ST_IDLE  | no transaction; winner gets ready and its request is latched
// ST_ISSUE | latched request presented on mem_req_*, waiting for mem_req_ready
// ST_WAIT  | request taken by memory, waiting for mem_resp_valid
module ysyx_mem_arbiter
  import ysyx_arb_pkg::*;
#(
  parameter int AW = ARB_AW_DEF,
  parameter int DW = ARB_DW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_resp_valid,
  output logic [DW-1:0]   ifu_rdata,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_addr,
  input  logic            lsu_wen,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic            lsu_resp_valid,
  output logic [DW-1:0]   lsu_rdata,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_resp_valid,
  input  logic [DW-1:0]   mem_rdata
);

  arb_state_e      state_q, state_d;
  arb_grant_e      grant_q;
  arb_grant_e      pick_grant;
  logic [AW-1:0]   addr_q;
  logic            wen_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] wmask_q;
  logic            accept;

`ifdef YSYX_ARB_RR_EN
  arb_grant_e last_grant_q;
`endif

  ysyx_arb_pick u_pick (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
`ifdef YSYX_ARB_RR_EN
    .last_grant (last_grant_q),
`endif
    .grant      (pick_grant)
  );

  assign accept = (state_q == ST_IDLE) && (ifu_req_valid || lsu_req_valid);

  // State register and request latch; the latch only loads on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= GNT_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
`ifdef YSYX_ARB_RR_EN
      last_grant_q <= GNT_IFU;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_q <= pick_grant;
`ifdef YSYX_ARB_RR_EN
        last_grant_q <= pick_grant;
`endif
        if (pick_grant == GNT_LSU) begin
          addr_q  <= lsu_addr;
          wen_q   <= lsu_wen;
          wdata_q <= lsu_wdata;
          wmask_q <= lsu_wmask;
        end else begin
          addr_q  <= ifu_addr;
          wen_q   <= 1'b0;
          wdata_q <= '0;
          wmask_q <= '0;
        end
      end
    end
  end

  // Next state and handshake outputs; everything forced low while in reset.
  always_comb begin
    state_d        = state_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ifu_req_ready = (pick_grant == GNT_IFU);
          lsu_req_ready = (pick_grant == GNT_LSU);
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          ifu_resp_valid = (grant_q == GNT_IFU);
          lsu_resp_valid = (grant_q == GNT_LSU);
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) begin
      ifu_req_ready  = 1'b0;
      lsu_req_ready  = 1'b0;
      mem_req_valid  = 1'b0;
      ifu_resp_valid = 1'b0;
      lsu_resp_valid = 1'b0;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign ifu_rdata = mem_rdata;
  assign lsu_rdata = mem_rdata;

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// Self-checking bench for ysyx_mem_arbiter: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
// Honours YSYX_ARB_RR_EN the same way the design does.
module tb_ysyx_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [AW-1:0]   ifu_addr;
  logic [DW-1:0]   ifu_rdata;
  logic            lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [AW-1:0]   lsu_addr;
  logic [DW-1:0]   lsu_wdata, lsu_rdata;
  logic [DW/8-1:0] lsu_wmask;
  logic            mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic [DW/8-1:0] mem_wmask;

  ysyx_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model: one outstanding transaction, described by who owns it,
  // whether memory has taken it yet, and the request it carries.
  bit              m_busy, m_sent, m_own_lsu, m_last_lsu;
  logic [AW-1:0]   m_addr;
  logic            m_wen;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_wmask;

  // Snapshot of DUT outputs from the most recent cycle.
  logic s_ifu_ready, s_lsu_ready, s_mem_req_valid, s_ifu_resp, s_lsu_resp;
  logic [DW-1:0] s_ifu_rdata, s_lsu_rdata, s_mem_wdata;
  logic [AW-1:0] s_mem_addr;
  logic [DW/8-1:0] s_mem_wmask;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns 1 when the LSU should win arbitration in an idle cycle.
  function automatic bit lsu_wins(input bit iv, input bit lv);
    if (iv && lv) begin
`ifdef YSYX_ARB_RR_EN
      return !m_last_lsu;
`else
      return 1'b1;
`endif
    end
    return lv;
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_sent = 0; m_own_lsu = 0; m_last_lsu = 0;
    m_addr = '0; m_wen = 0; m_wdata = '0; m_wmask = '0;
  endfunction

  // One clock cycle: check outputs mid-cycle, then advance the model at the edge.
  task automatic cyc();
    bit lw, any, resp;
    @(negedge clk);
    lw   = lsu_wins(ifu_req_valid, lsu_req_valid);
    any  = ifu_req_valid || lsu_req_valid;
    resp = !rst && m_busy && m_sent && mem_resp_valid;
    s_ifu_ready = ifu_req_ready;  s_lsu_ready = lsu_req_ready;
    s_mem_req_valid = mem_req_valid;
    s_ifu_resp = ifu_resp_valid;  s_lsu_resp = lsu_resp_valid;
    s_ifu_rdata = ifu_rdata;      s_lsu_rdata = lsu_rdata;
    s_mem_addr = mem_addr; s_mem_wdata = mem_wdata; s_mem_wmask = mem_wmask;
    chk("ifu_req_ready", ifu_req_ready, !rst && !m_busy && any && !lw);
    chk("lsu_req_ready", lsu_req_ready, !rst && !m_busy && any && lw);
    chk("mem_req_valid", mem_req_valid, !rst && m_busy && !m_sent);
    chk("ifu_resp_valid", ifu_resp_valid, resp && !m_own_lsu);
    chk("lsu_resp_valid", lsu_resp_valid, resp && m_own_lsu);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wen", mem_wen, m_wen);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("mem_wmask", mem_wmask, m_wmask);
    if (resp && !m_own_lsu) chk("ifu_rdata", ifu_rdata, mem_rdata);
    if (resp && m_own_lsu)  chk("lsu_rdata", lsu_rdata, mem_rdata);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (!m_busy && any) begin
      m_busy = 1; m_sent = 0; m_own_lsu = lw; m_last_lsu = lw;
      m_addr  = lw ? lsu_addr : ifu_addr;
      m_wen   = lw ? lsu_wen : 1'b0;
      m_wdata = lw ? lsu_wdata : '0;
      m_wmask = lw ? lsu_wmask : '0;
    end else if (m_busy && !m_sent && mem_req_ready) begin
      m_sent = 1;
    end else if (m_busy && m_sent && mem_resp_valid) begin
      m_busy = 0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
  endtask

  initial begin
    model_reset();
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;

    // Reset holds every handshake low even with traffic on the inputs.
    ifu_req_valid = 1; lsu_req_valid = 1; mem_resp_valid = 1; mem_req_ready = 1;
    cyc();
    chk("rst_ifu_ready", s_ifu_ready, 1'b0);
    chk("rst_mem_req_valid", s_mem_req_valid, 1'b0);
    cyc();
    idle_inputs();
    rst = 0;
    cyc();
    chk("rst_mem_addr_zero", s_mem_addr, '0);

    // Single IFU fetch at minimum latency.
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1;
    cyc();
    chk("fetch_accept", s_ifu_ready, 1'b1);
    ifu_req_valid = 0;
    cyc();
    chk("fetch_issue", s_mem_req_valid, 1'b1);
    chk("fetch_addr", s_mem_addr, 32'h8000_0000);
    mem_resp_valid = 1; mem_rdata = 32'h0000_0413;
    cyc();
    chk("fetch_resp", s_ifu_resp, 1'b1);
    chk("fetch_rdata", s_ifu_rdata, 32'h0000_0413);
    mem_resp_valid = 0;

    // Simultaneous requests: LSU first, IFU in the idle after LSU completes.
    ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
    lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 0;
    cyc();
    chk("tie1_lsu_ready", s_lsu_ready, 1'b1);
    chk("tie1_ifu_ready", s_ifu_ready, 1'b0);
    lsu_req_valid = 0;
    cyc();
    chk("tie1_ifu_stall", s_ifu_ready, 1'b0);
    mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
    cyc();
    chk("tie1_lsu_resp", s_lsu_resp, 1'b1);
    chk("tie1_lsu_rdata", s_lsu_rdata, 32'h1234_5678);
    mem_resp_valid = 0;
    cyc();
    chk("tie1_ifu_next", s_ifu_ready, 1'b1);
    ifu_req_valid = 0;
    cyc();
    mem_resp_valid = 1;
    cyc();
    mem_resp_valid = 0;

    // Two ties in a row: the second one shows the tie-break policy.
    ifu_req_valid = 1; lsu_req_valid = 1;
    cyc();
    chk("tie2_first_lsu", s_lsu_ready, 1'b1);
    cyc();
    mem_resp_valid = 1;
    cyc();
    mem_resp_valid = 0;
    cyc();
`ifdef YSYX_ARB_RR_EN
    chk("tie3_rr_ifu", s_ifu_ready, 1'b1);
`else
    chk("tie3_fixed_lsu", s_lsu_ready, 1'b1);
`endif
    ifu_req_valid = 0; lsu_req_valid = 0;
    cyc();
    mem_resp_valid = 1;
    cyc();
    mem_resp_valid = 0;

    // LSU write stalled by memory for three cycles; fields must hold.
    lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF; mem_req_ready = 0;
    cyc();
    lsu_req_valid = 0; lsu_addr = 32'h0; lsu_wdata = 32'h0; lsu_wen = 0; lsu_wmask = 4'h0;
    for (int i = 0; i < 4; i++) begin
      mem_req_ready = (i == 3);
      lsu_req_valid = (i == 1);
      cyc();
      chk("wr_hold_valid", s_mem_req_valid, 1'b1);
      chk("wr_hold_addr", s_mem_addr, 32'h8000_1000);
      chk("wr_hold_wdata", s_mem_wdata, 32'hDEAD_BEEF);
      chk("wr_hold_wmask", s_mem_wmask, 4'hF);
      chk("wr_lsu_ready", s_lsu_ready, 1'b0);
    end
    lsu_req_valid = 0; mem_req_ready = 1;
    cyc();
    chk("wr_waits_resp", s_lsu_resp, 1'b0);
    mem_resp_valid = 1;
    cyc();
    chk("wr_complete", s_lsu_resp, 1'b1);
    mem_resp_valid = 0;

    // Stray responses in IDLE and ISSUE are ignored.
    mem_resp_valid = 1;
    cyc();
    chk("stray_idle_ifu", s_ifu_resp, 1'b0);
    chk("stray_idle_lsu", s_lsu_resp, 1'b0);
    mem_resp_valid = 0; ifu_req_valid = 1; ifu_addr = 32'h8000_0100; mem_req_ready = 0;
    cyc();
    ifu_req_valid = 0; mem_resp_valid = 1;
    cyc();
    chk("stray_issue_resp", s_ifu_resp, 1'b0);
    mem_resp_valid = 0;
    cyc();
    chk("stray_issue_hold", s_mem_req_valid, 1'b1);
    mem_req_ready = 1;
    cyc();
    mem_resp_valid = 1;
    cyc();
    chk("stray_then_resp", s_ifu_resp, 1'b1);
    mem_resp_valid = 0;

    // Reset during WAIT abandons the transaction.
    ifu_req_valid = 1; ifu_addr = 32'h8000_0200;
    cyc();
    ifu_req_valid = 0;
    cyc();
    rst = 1;
    cyc();
    rst = 0; mem_resp_valid = 1;
    cyc();
    chk("abandon_ifu_resp", s_ifu_resp, 1'b0);
    chk("abandon_lsu_resp", s_lsu_resp, 1'b0);
    chk("abandon_idle", s_mem_req_valid, 1'b0);
    mem_resp_valid = 0; ifu_req_valid = 1; ifu_addr = 32'h8000_0300;
    cyc();
    chk("after_rst_accept", s_ifu_ready, 1'b1);
    ifu_req_valid = 0;
    cyc();
    chk("after_rst_addr", s_mem_addr, 32'h8000_0300);
    mem_resp_valid = 1; mem_rdata = 32'hCAFE_0001;
    cyc();
    chk("after_rst_resp", s_ifu_resp, 1'b1);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rst            = ($urandom_range(0, 49) == 0);
      ifu_req_valid  = $urandom_range(0, 1);
      ifu_addr       = $urandom;
      lsu_req_valid  = $urandom_range(0, 1);
      lsu_addr       = $urandom;
      lsu_wen        = $urandom_range(0, 1);
      lsu_wdata      = $urandom;
      lsu_wmask      = 4'($urandom_range(0, 15));
      mem_req_ready  = $urandom_range(0, 1);
      mem_resp_valid = $urandom_range(0, 1);
      mem_rdata      = $urandom;
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
